// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
package serial_add_ctrl_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_fa_bit.sv
// One-bit full adder used as the serial arithmetic element.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : fa_bit

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one result bit per RUN cycle, LSB first.
//
// Handshake: start is a level request sampled only in IDLE. The cycle after
// the accepting edge busy rises and stays high for exactly WIDTH cycles; done
// then pulses for one cycle with sum/cout/overflow already valid. Requests
// seen in RUN or DONE are dropped (no queuing), and results hold until the
// next completion.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s, fa_co;
  logic accept;
  logic last_bit;

  fa_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = (state_q == ST_IDLE) && start;
  assign last_bit = (cnt_q == CNT_LAST);

  // Next-state and status outputs; status is decoded straight from the state.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand capture on accept, one bit per RUN cycle.
  always_comb begin
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
      carry_d  = fa_co;
      // Counter holds at its last value so it never wraps.
      cnt_d    = last_bit ? cnt_q : cnt_q + CNT_W'(1);
      if (last_bit) begin
        // carry_q here is the carry into the MSB, fa_co the carry out of it.
        sum_d  = {fa_s, res_sh_q[WIDTH-1:1]};
        cout_d = fa_co;
        ovf_d  = carry_q ^ fa_co;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH = 8).
module tb_serial_add_ctrl;

  localparam int W    = 8;
  localparam int HALF = 1 << (W - 1);
  localparam int FULL = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  // Expected results as {overflow, cout, sum}, in completion order.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow by range test.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci, input logic s);
    int ua, ub, sa, sb, full, sr;
    logic [W-1:0] r;
    logic co, ov;
    ua = int'(x);
    ub = int'(y);
    sa = (ua >= HALF) ? ua - FULL : ua;
    sb = (ub >= HALF) ? ub - FULL : ub;
    if (s) begin
      full = ua - ub;
      co   = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + int'(ci);
      co   = (full >= FULL);
      sr   = sa + sb + int'(ci);
    end
    r  = W'(full);
    ov = (sr > HALF - 1) || (sr < -HALF);
    return {ov, co, r};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("pending_op", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("sb_sum", 32'(sum), 32'(e[W-1:0]));
        check("sb_cout", 32'(cout), 32'(e[W]));
        check("sb_ovf", 32'(overflow), 32'(e[W+1]));
      end
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input bit inject);
    logic [W+1:0] r;
    r = ref_model(x, y, ci, s);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(r);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("done_in_run", 32'(done), 32'd0);
      check("hold_result", 32'({overflow, cout, sum}), 32'(last_res));
      if (inject && i == 2) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("result", 32'({overflow, cout, sum}), 32'(r));
    last_res = r;
    @(posedge clk); #1;
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_reset_mid(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("busy_pre_rst", 32'(busy), 32'd1);
      if (i == 3) rst_n = 1'b0;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    last_res = '0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'({overflow, cout, sum}), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(done), 32'd0);
    end
  endtask

  task automatic run_held(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
    int cyc, last_cyc, n;
    logic [W+1:0] r;
    r = ref_model(x, y, ci, s);
    repeat (3) exp_q.push_back(r);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    cyc = 0; last_cyc = 0; n = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (n > 0) check("held_period", 32'(cyc - last_cyc), 32'(W + 2));
        check("held_result", 32'({overflow, cout, sum}), 32'(r));
        last_cyc = cyc;
        n++;
      end
    end
    start = 1'b0;
    check("held_pulses", 32'(n), 32'd3);
    last_res = r;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held_idle", 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'h11; b = 8'h22;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'({overflow, cout, sum}), 32'd0);

    // First accept happens on the first edge with rst_n high.
    rst_n = 1'b1;
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
    check("vec1", 32'({overflow, cout, sum}), 32'({1'b1, 1'b0, 8'h8D}));
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check("vec2", 32'({overflow, cout, sum}), 32'({1'b0, 1'b1, 8'h00}));
    run_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
    check("vec3", 32'({overflow, cout, sum}), 32'({1'b0, 1'b0, 8'hF0}));
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    check("vec4", 32'({overflow, cout, sum}), 32'({1'b1, 1'b1, 8'h7F}));

    // Start pulsed mid-RUN must be ignored.
    d0 = done_cnt;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    repeat (W + 2) begin
      @(posedge clk); #1;
      check("no_queued_op", 32'(busy | done), 32'd0);
    end
    check("vec5_sum", 32'(sum), 32'h02);
    check("vec5_pulses", 32'(done_cnt - d0), 32'd1);

    run_reset_mid(8'h12, 8'h34);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    check("vec6", 32'(sum), 32'h07);

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    run_held(8'h3C, 8'h5D, 1'b1, 1'b0);
    run_held(8'h20, 8'h90, 1'b0, 1'b1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8 (legal 2..32), giving the operand and result width in bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  Sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  Synchronous active-low reset.
REQ-005 start  input  1  Request to begin an operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  Operand A; captured on accept.
REQ-007 b  input  WIDTH  Operand B; captured on accept.
REQ-008 cin  input  1  Carry-in for add mode; captured on accept.
REQ-009 sub  input  1  1 = compute a - b; captured on accept.
REQ-010 busy  output  1  High while in RUN.
REQ-011 done  output  1  Single-cycle completion pulse, high only in DONE.
REQ-012 sum  output  WIDTH  Result register.
REQ-013 cout  output  1  Carry out of the MSB.
REQ-014 overflow  output  1  Signed overflow of the result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 Accept: on a rising edge with state IDLE and start=1, the block SHALL capture a and b into shift registers and clear the bit counter to 0.
REQ-017 Accept (sub=1): the block SHALL capture ~b and force the carry flop to 1; cin is ignored.
REQ-018 Accept (sub=0): the block SHALL load the carry flop from cin.
REQ-019 Accept SHALL move the FSM to RUN.
REQ-020 Each RUN cycle SHALL feed the LSBs of the A/B shift registers and the carry flop through one 1-bit full adder.
REQ-021 Each RUN cycle SHALL shift the sum bit into the result shift register from the MSB side, update the carry flop, shift the operands right and increment the counter.
REQ-022 At the RUN edge where counter = WIDTH-1, the block SHALL load sum from the completed shift register and cout from the final carry.
REQ-023 At that same edge, the block SHALL load overflow with (carry into MSB) XOR (carry out of MSB) and move to DONE.
REQ-024 Latency: with accept at edge k, busy SHALL be high for exactly WIDTH cycles, done SHALL be high for the single cycle after edge k+WIDTH, and sum, cout and overflow SHALL be valid in that same cycle.
REQ-025 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-026 start SHALL be ignored in RUN and DONE; no queuing; captured operands are unaffected.
REQ-027 With start held high continuously, the block SHALL accept again on the first IDLE edge, giving one IDLE cycle between done and the next busy.
REQ-028 sum, cout and overflow SHALL change only at completion and hold through IDLE and any subsequent RUN until the next completion.
REQ-029 The counter SHALL be ceil(log2(WIDTH)) bits and SHALL never wrap within an operation.
REQ-030 Arithmetic SHALL be modulo 2^WIDTH; cout in sub mode is the unsigned no-borrow flag (1 = a >= b).

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, sum, cout, overflow, the counter, the carry flop and all shift registers to 0.
REQ-032 Reset SHALL take effect from any state, including mid-RUN; the partial operation is discarded and done is never pulsed for it.
REQ-033 start SHALL be ignored while rst_n=0; the first accept can occur on the first edge with rst_n=1.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-035 The 1-bit full adder SHALL be a single instantiated sub-module, fa_bit (a, b, ci -> s, co).
REQ-036 All other logic (FSM, counter, shift registers, carry flop, output registers) SHALL reside in serial_add_ctrl.

Verification
REQ-037 WIDTH=8, a=0x5A, b=0x33, cin=0, sub=0 -> sum=0x8D, cout=0, overflow=1; busy for 8 cycles; done in cycle 9 after accept.
REQ-038 a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, overflow=0.
REQ-039 a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, overflow=0; and a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
REQ-040 Accept 0x01+0x01, then pulse start with a=0xAA, b=0x55 in RUN cycle 3 -> sum=0x02 and exactly one done pulse.
REQ-041 rst_n=0 in RUN cycle 4 -> next cycle busy=0, done=0, sum=0x00; a new start (0x03+0x04) then completes with sum=0x07.
REQ-042 start held high with fixed operands -> done pulses every WIDTH+2 cycles, each with an identical result.
